muldiv_station_arbiter: RTL and testbench



---
 rtl/muldiv_station_arbiter.sv | 144 ++++++++++++++
 tb/tb_muldiv_station_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_station_arbiter.sv
// Allocation and writeback controller for a pool of multiply/divide
// reservation stations. It hands the lowest free station to the issue stage
// and round-robin arbitrates finished stations into a one-entry holding
// register that drives the common-data-bus writer port.
//
// Handshakes: a station is allocated in any cycle where issue_valid and
// issue_ready are both high. The held result transfers in any cycle where
// bus_request and bus_grant are both high. bus_grant without bus_request is
// ignored. bus_source and bus_value stay stable while bus_request is high and
// bus_grant is low.
module muldiv_station_arbiter #(
  parameter int STATION_COUNT      = 4,
  parameter int SIZE               = 32,
  parameter int STATION_INDEX_SIZE = 3,
  parameter int TAG_BASE           = 0
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic                                  issue_valid,
  output logic                                  issue_ready,
  output logic [STATION_INDEX_SIZE-1:0]         issue_tag,
  output logic [STATION_COUNT-1:0]              set_occupied,
  output logic [STATION_COUNT-1:0]              reset_occupied,
  input  logic [STATION_COUNT-1:0]              station_result_ready,
  input  logic [STATION_COUNT*SIZE-1:0]         station_result,
  output logic                                  bus_request,
  input  logic                                  bus_grant,
  output logic [STATION_INDEX_SIZE-1:0]         bus_source,
  output logic [SIZE-1:0]                       bus_value,
  output logic [$clog2(STATION_COUNT+1)-1:0]    busy_count
);

  localparam int PW = $clog2(STATION_COUNT);
  localparam int CW = $clog2(STATION_COUNT + 1);

  logic [STATION_COUNT-1:0]      busy;
  logic [PW-1:0]                 rr_ptr;
  logic                          hold_valid;
  logic [STATION_INDEX_SIZE-1:0] hold_tag;
  logic [SIZE-1:0]               hold_value;

  logic                          alloc_found;
  logic [PW-1:0]                 alloc_idx;
  logic                          alloc_fire;
  logic [STATION_COUNT-1:0]      elig;
  logic                          load_ok;
  logic                          pick_found;
  logic [PW-1:0]                 pick_idx;
  logic [PW-1:0]                 scan_idx;
  logic                          load_fire;

  // Lowest-index free station, taken from the registered busy mask so a
  // station retired this cycle is only reusable from the next cycle on.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = STATION_COUNT - 1; i >= 0; i--) begin
      if (!busy[PW'(i)]) begin
        alloc_found = 1'b1;
        alloc_idx   = PW'(i);
      end
    end
  end

  // Issue-side outputs; allocation is blocked during reset and flush.
  always_comb begin
    issue_ready  = alloc_found && !flush && !reset;
    issue_tag    = alloc_found ? STATION_INDEX_SIZE'(TAG_BASE + int'(alloc_idx))
                               : STATION_INDEX_SIZE'(TAG_BASE);
    alloc_fire   = issue_valid && issue_ready;
    set_occupied = '0;
    if (alloc_fire) set_occupied[alloc_idx] = 1'b1;
  end

  // Round-robin pick of the first eligible station at or after rr_ptr.
  always_comb begin
    elig       = busy & station_result_ready & ~set_occupied;
    load_ok    = (!hold_valid || bus_grant) && !flush && !reset;
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = 0; i < STATION_COUNT; i++) begin
      scan_idx = PW'((int'(rr_ptr) + i) % STATION_COUNT);
      if (!pick_found && elig[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
    load_fire = load_ok && pick_found;
  end

  // Retire pulse: the winner on a load, every busy station on a flush.
  always_comb begin
    reset_occupied = '0;
    if (reset) begin
      reset_occupied = '0;
    end else if (flush) begin
      reset_occupied = busy;
    end else if (load_fire) begin
      reset_occupied[pick_idx] = 1'b1;
    end
  end

  // Bus outputs come straight from the holding register.
  always_comb begin
    bus_request = hold_valid;
    bus_source  = hold_tag;
    bus_value   = hold_value;
  end

  // Busy mask, round-robin pointer, holding register and occupancy count.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy       <= '0;
      rr_ptr     <= '0;
      hold_valid <= 1'b0;
      hold_tag   <= '0;
      hold_value <= '0;
      busy_count <= '0;
    end else if (flush) begin
      // A held result is dropped even if the bus grants it this cycle.
      busy       <= '0;
      hold_valid <= 1'b0;
      busy_count <= '0;
    end else begin
      busy <= (busy | set_occupied) & ~reset_occupied;
      if (load_fire) begin
        hold_valid <= 1'b1;
        hold_tag   <= STATION_INDEX_SIZE'(TAG_BASE + int'(pick_idx));
        hold_value <= station_result[int'(pick_idx)*SIZE +: SIZE];
        rr_ptr     <= (pick_idx == PW'(STATION_COUNT - 1)) ? '0 : pick_idx + PW'(1);
      end else if (bus_grant) begin
        hold_valid <= 1'b0;
      end
      unique case ({alloc_fire, load_fire})
        2'b10:   busy_count <= busy_count + CW'(1);
        2'b01:   busy_count <= busy_count - CW'(1);
        default: busy_count <= busy_count;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_station_arbiter.sv
// Randomized and directed bench for muldiv_station_arbiter against a
// behavioural model of the station pool kept as plain arrays.
module tb_muldiv_station_arbiter;

  localparam int N    = 4;
  localparam int SIZE = 32;
  localparam int IS   = 3;
  localparam int TB   = 2;
  localparam int CW   = $clog2(N + 1);

  // ---------------- clock / reset / signals ----------------
  logic              clock = 1'b0;
  logic              reset;
  logic              flush;
  logic              issue_valid;
  logic              issue_ready;
  logic [IS-1:0]     issue_tag;
  logic [N-1:0]      set_occupied;
  logic [N-1:0]      reset_occupied;
  logic [N-1:0]      station_result_ready;
  logic [N*SIZE-1:0] station_result;
  logic              bus_request;
  logic              bus_grant;
  logic [IS-1:0]     bus_source;
  logic [SIZE-1:0]   bus_value;
  logic [CW-1:0]     busy_count;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  muldiv_station_arbiter #(
    .STATION_COUNT(N), .SIZE(SIZE), .STATION_INDEX_SIZE(IS), .TAG_BASE(TB)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
    .set_occupied(set_occupied), .reset_occupied(reset_occupied),
    .station_result_ready(station_result_ready), .station_result(station_result),
    .bus_request(bus_request), .bus_grant(bus_grant),
    .bus_source(bus_source), .bus_value(bus_value), .busy_count(busy_count)
  );

  // ---------------- reference model ----------------
  bit              m_busy[N];
  int              m_rr;
  bit              m_hv;
  int              m_htag;
  logic [SIZE-1:0] m_hval;

  bit              e_ready;
  int              e_tag;
  int              e_set;
  int              e_ret;
  bit              e_load;
  int              e_pick;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_busy[i];
    return c;
  endfunction

  // Expected combinational behaviour for the inputs currently applied.
  task automatic model_eval();
    int k = -1;
    int mask = 0;
    for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) k = i;
    for (int i = 0; i < N; i++) if (m_busy[i]) mask |= (1 << i);
    e_ready = (k >= 0) && !flush && !reset;
    e_tag   = (k >= 0) ? TB + k : TB;
    e_set   = (issue_valid && e_ready) ? (1 << k) : 0;
    e_load  = 1'b0;
    e_pick  = 0;
    if (!reset && !flush && (!m_hv || bus_grant)) begin
      for (int i = 0; i < N; i++) begin
        int s = (m_rr + i) % N;
        if (!e_load && m_busy[s] && station_result_ready[s] && ((e_set >> s) & 1) == 0) begin
          e_load = 1'b1;
          e_pick = s;
        end
      end
    end
    if (reset)       e_ret = 0;
    else if (flush)  e_ret = mask;
    else if (e_load) e_ret = 1 << e_pick;
    else             e_ret = 0;
  endtask

  task automatic compare_all();
    check("issue_ready",    issue_ready,    64'(e_ready));
    check("issue_tag",      issue_tag,      64'(e_tag));
    check("set_occupied",   set_occupied,   64'(e_set));
    check("reset_occupied", reset_occupied, 64'(e_ret));
    check("bus_request",    bus_request,    64'(m_hv));
    check("bus_source",     bus_source,     64'(m_htag));
    check("bus_value",      bus_value,      64'(m_hval));
    check("busy_count",     busy_count,     64'(model_count()));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit fl, input bit iv, input logic [N-1:0] rdy, input bit g);
    @(negedge clock);
    reset                = 1'b0;
    flush                = fl;
    issue_valid          = iv;
    station_result_ready = rdy;
    bus_grant            = g;
    #1;
    model_eval();
    compare_all();
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_rr = 0; m_hv = 1'b0; m_htag = 0; m_hval = '0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_hv = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) if ((e_set >> i) & 1) m_busy[i] = 1'b1;
      if (e_load) begin
        m_busy[e_pick] = 1'b0;
        m_hv   = 1'b1;
        m_htag = TB + e_pick;
        m_hval = station_result[e_pick*SIZE +: SIZE];
        m_rr   = (e_pick + 1) % N;
      end else if (bus_grant) begin
        m_hv = 1'b0;
      end
    end
    #1;
  endtask

  task automatic cyc(input bit fl, input bit iv, input logic [N-1:0] rdy, input bit g);
    drive(fl, iv, rdy, g);
    tick();
  endtask

  task automatic set_res(input int k, input logic [SIZE-1:0] v);
    station_result[k*SIZE +: SIZE] = v;
  endtask

  task automatic do_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      reset = 1'b1; flush = 1'b0; issue_valid = 1'b1;
      station_result_ready = '1; bus_grant = 1'b1;
      #1;
      model_eval();
      check("rst_issue_ready", issue_ready,    64'(e_ready));
      check("rst_set",         set_occupied,   64'(e_set));
      check("rst_ret",         reset_occupied, 64'(e_ret));
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; bus_grant = 1'b0;
    station_result_ready = '0;
    for (int i = 0; i < N; i++) station_result[i*SIZE +: SIZE] = $urandom;
    do_reset();

    // Outputs after reset.
    drive(0, 0, '0, 0);
    check("post_rst_ready", issue_ready, 1);
    check("post_rst_tag",   issue_tag,   TB);
    check("post_rst_src",   bus_source,  0);
    check("post_rst_val",   bus_value,   0);
    check("post_rst_cnt",   busy_count,  0);
    tick();

    // Fill pool.
    for (int c = 0; c < 5; c++) begin
      drive(0, 1, '0, 0);
      if (c < 4) begin
        check("fill_tag", issue_tag,    64'(TB + c));
        check("fill_set", set_occupied, 64'(1 << c));
      end else begin
        check("fill_ready", issue_ready, 0);
        check("fill_cnt",   busy_count,  4);
      end
      tick();
    end

    // Writeback latency: free stations 0 and 2, leaving 1 and 3 busy.
    cyc(0, 0, 4'b0101, 1);
    cyc(0, 0, 4'b0101, 1);
    cyc(0, 0, 4'b0000, 1);
    set_res(1, 32'h1234);
    drive(0, 0, 4'b0010, 1);
    check("wb_ret", reset_occupied, 4'b0010);
    tick();
    drive(0, 0, 4'b0000, 1);
    check("wb_req", bus_request, 1);
    check("wb_src", bus_source,  3);
    check("wb_val", bus_value,   32'h1234);
    tick();
    drive(0, 0, 4'b0000, 0);
    check("wb_cnt", busy_count, 1);
    tick();

    // Round-robin over a full pool.
    do_reset();
    for (int c = 0; c < N; c++) cyc(0, 1, '0, 0);
    for (int i = 0; i < N; i++) set_res(i, $urandom);
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 4'b1111, 1);
      if (c > 0) check("rr_tag", bus_source, 64'(TB + c - 1));
      tick();
    end
    for (int c = 0; c < 3; c++) cyc(0, 1, '0, 1);
    cyc(0, 0, 4'b0001, 1);
    cyc(0, 1, '0, 1);
    drive(0, 0, 4'b0101, 1);
    check("rr_first_ret", reset_occupied, 4'b0100);
    tick();
    drive(0, 0, 4'b0101, 1);
    check("rr_first_tag", bus_source, 4);
    tick();
    drive(0, 0, 4'b0000, 1);
    check("rr_second_tag", bus_source, 2);
    tick();

    // Backpressure.
    for (int c = 0; c < 3; c++) cyc(0, 1, '0, 0);
    set_res(1, 32'hDEAD);
    cyc(0, 0, 4'b0010, 0);
    set_res(2, 32'hBEEF);
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 4'b0100, 0);
      check("bp_val", bus_value,      32'hDEAD);
      check("bp_src", bus_source,     3);
      check("bp_ret", reset_occupied, 0);
      tick();
    end
    drive(0, 0, 4'b0100, 1);
    check("bp_grant_ret", reset_occupied, 4'b0100);
    tick();
    drive(0, 0, 4'b0000, 1);
    check("bp_new_val", bus_value, 32'hBEEF);
    tick();

    // Same-cycle free/allocate on a full pool.
    cyc(0, 1, '0, 0);
    cyc(0, 1, '0, 0);
    drive(0, 1, 4'b0001, 1);
    check("sc_ready", issue_ready,    0);
    check("sc_ret",   reset_occupied, 4'b0001);
    tick();
    drive(0, 1, 4'b0000, 1);
    check("sc_tag", issue_tag,    TB);
    check("sc_set", set_occupied, 4'b0001);
    tick();

    // Flush with three busy and a held result.
    cyc(0, 0, 4'b0010, 0);
    drive(1, 1, 4'b1111, 1);
    check("fl_ret",   reset_occupied, 4'b1101);
    check("fl_ready", issue_ready,    0);
    tick();
    drive(0, 0, 4'b0000, 0);
    check("fl_req", bus_request, 0);
    check("fl_cnt", busy_count,  0);
    tick();

    // Reset mid-run.
    cyc(0, 1, '0, 0);
    cyc(0, 1, '0, 0);
    cyc(0, 0, 4'b0001, 0);
    do_reset();
    drive(0, 0, 4'b0000, 0);
    check("mr_req",   bus_request, 0);
    check("mr_cnt",   busy_count,  0);
    check("mr_ready", issue_ready, 1);
    tick();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) set_res(i, $urandom);
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0,
            N'($urandom_range(0, (1 << N) - 1)), $urandom_range(0, 3) != 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
